// File: rtl/saradc_seq_avg.sv
// Conversion sequencer and averager for the SAR ADC: paces starts at a fixed period,
// accumulates 2**LOG2_N samples and presents the rounded average on a valid/ready port.
module saradc_seq_avg #(
    parameter int DATA_W  = 5,
    parameter int LOG2_N  = 2,
    parameter int PERIOD  = 64,
    parameter int TIMEOUT = 63
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              nEndCnv,
    input  logic [DATA_W-1:0] adcData,
    output logic              nStartCnv,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic              err_timeout,
    output logic              overrun,
    output logic [2:0]        state_dbg
);

    localparam int SW   = DATA_W + LOG2_N;
    localparam int CW   = LOG2_N + 1;
    localparam int PW   = $clog2(PERIOD);
    localparam int TW   = $clog2(TIMEOUT);
    localparam int HALF = (1 << LOG2_N) / 2;

    localparam logic [CW-1:0] N_SAMP  = CW'(1 << LOG2_N);
    localparam logic [PW-1:0] PER_MAX = PW'(PERIOD - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t          state;
    logic [SW-1:0]   sum;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   per_tmr;
    logic [TW-1:0]   wait_tmr;
    logic [SW-1:0]   rounded;
    logic [DATA_W-1:0] avg_next;
    logic            batch_done;
    logic            accept;

    // Adding half an LSB before the shift rounds to nearest; the sum never reaches 2**SW.
    always_comb begin
        rounded    = sum + SW'(HALF);
        avg_next   = DATA_W'(rounded >> LOG2_N);
        batch_done = (state == GAP) && (cnt == N_SAMP);
        accept     = avg_valid && avg_ready;
    end

    assign state_dbg = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            nStartCnv   <= 1'b1;
            avg_out     <= '0;
            avg_valid   <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
            sum         <= '0;
            cnt         <= '0;
            per_tmr     <= '0;
            wait_tmr    <= '0;
        end else begin
            if (per_tmr != PER_MAX) per_tmr <= per_tmr + 1'b1;

            // Sticky-flag set events below are later assignments, so they beat clear.
            if (clear) begin
                err_timeout <= 1'b0;
                overrun     <= 1'b0;
            end

            // Output port: a result transfers on a clock where avg_valid & avg_ready;
            // avg_out holds while valid and unaccepted, unless a newer result replaces it.
            if (batch_done) begin
                avg_out   <= avg_next;
                avg_valid <= 1'b1;
                if (avg_valid && !avg_ready) overrun <= 1'b1;
            end else if (accept) begin
                avg_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    nStartCnv <= 1'b1;
                    if (enable) begin
                        state     <= START;
                        nStartCnv <= 1'b0;
                        sum       <= '0;
                        cnt       <= '0;
                        per_tmr   <= '0;
                    end
                end
                START: begin
                    state    <= WAIT_BUSY;
                    wait_tmr <= '0;
                end
                WAIT_BUSY: begin
                    if (nEndCnv) begin
                        nStartCnv <= 1'b1;
                        state     <= WAIT_DONE;
                        wait_tmr  <= '0;
                    end else if (wait_tmr == TO_MAX) begin
                        err_timeout <= 1'b1;
                        nStartCnv   <= 1'b1;
                        sum         <= '0;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else begin
                        wait_tmr <= wait_tmr + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!nEndCnv) begin
                        sum   <= sum + SW'(adcData);
                        cnt   <= cnt + 1'b1;
                        state <= GAP;
                    end else if (wait_tmr == TO_MAX) begin
                        err_timeout <= 1'b1;
                        nStartCnv   <= 1'b1;
                        sum         <= '0;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else begin
                        wait_tmr <= wait_tmr + 1'b1;
                    end
                end
                GAP: begin
                    if (batch_done) begin
                        sum <= '0;
                        cnt <= '0;
                    end
                    // Leaving on enable=0 throws away any partial batch.
                    if (!enable) begin
                        state <= IDLE;
                        sum   <= '0;
                        cnt   <= '0;
                    end else if (per_tmr == PER_MAX) begin
                        state     <= START;
                        nStartCnv <= 1'b0;
                        per_tmr   <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    nStartCnv <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_saradc_seq_avg.sv
// Directed bench for saradc_seq_avg: instance 0 runs PERIOD=64, instance 1 runs PERIOD=2,
// each driven by a behavioural SAR ADC model.
module tb_saradc_seq_avg;

    localparam int DW = 5;

    logic          clock = 1'b0;
    logic          rstn[2], en[2], clr[2], nend[2], ready[2];
    logic          nstart[2], avgv[2], errt[2], ovr[2];
    logic [DW-1:0] adat[2], avgo[2];
    logic [2:0]    st[2];

    int adc_mode[2] = '{0, 0};   // 0 normal, 1 never raises nEndCnv, 2 nEndCnv stuck high
    int conv_len[2] = '{10, 20};
    int samples_done[2] = '{0, 0};
    int adc_q0[$], adc_q1[$];
    int start_q0[$], start_q1[$];
    logic [DW-1:0] exp_q[$];
    int cyc = 0, busy_cnt = 0, done_cnt = 0;
    int n_tests = 0, n_fail = 0;
    logic prev_ns[2] = '{1'b1, 1'b1};

    always #5 clock = ~clock;

    saradc_seq_avg #(.DATA_W(DW), .LOG2_N(2), .PERIOD(64), .TIMEOUT(63)) dut (
        .clock(clock), .reset(rstn[0]), .enable(en[0]), .clear(clr[0]),
        .nEndCnv(nend[0]), .adcData(adat[0]), .nStartCnv(nstart[0]),
        .avg_out(avgo[0]), .avg_valid(avgv[0]), .avg_ready(ready[0]),
        .err_timeout(errt[0]), .overrun(ovr[0]), .state_dbg(st[0])
    );

    saradc_seq_avg #(.DATA_W(DW), .LOG2_N(2), .PERIOD(2), .TIMEOUT(63)) dut2 (
        .clock(clock), .reset(rstn[1]), .enable(en[1]), .clear(clr[1]),
        .nEndCnv(nend[1]), .adcData(adat[1]), .nStartCnv(nstart[1]),
        .avg_out(avgo[1]), .avg_valid(avgv[1]), .avg_ready(ready[1]),
        .err_timeout(errt[1]), .overrun(ovr[1]), .state_dbg(st[1])
    );

    always @(posedge clock) cyc <= cyc + 1;

    // Start-edge timestamps and wait-state occupancy for instance 0.
    always @(negedge clock) begin
        if (prev_ns[0] && !nstart[0]) start_q0.push_back(cyc);
        if (prev_ns[1] && !nstart[1]) start_q1.push_back(cyc);
        prev_ns[0] = nstart[0];
        prev_ns[1] = nstart[1];
        if (st[0] == 3'd2) busy_cnt++;
        if (st[0] == 3'd3) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] next_sample(input int i);
        int v = 0;
        if (i == 0 && adc_q0.size() > 0) v = adc_q0.pop_front();
        if (i == 1 && adc_q1.size() > 0) v = adc_q1.pop_front();
        return DW'(v);
    endfunction

    task automatic adc_model(input int i);
        nend[i] = 1'b0;
        adat[i] = '0;
        forever begin
            @(negedge clock);
            if (rstn[i] && !nstart[i] && adc_mode[i] != 1) begin
                nend[i] = 1'b1;
                for (int k = 0; k < conv_len[i] && rstn[i]; k++) @(negedge clock);
                while (adc_mode[i] == 2 && rstn[i]) @(negedge clock);
                if (rstn[i]) begin
                    adat[i] = next_sample(i);
                    samples_done[i]++;
                end
                nend[i] = 1'b0;
            end
        end
    endtask

    initial begin
        fork
            adc_model(0);
            adc_model(1);
        join_none
    end

    function automatic int sig(input int i, input int what);
        case (what)
            0:       return int'(st[i]);
            1:       return int'(avgv[i]);
            2:       return samples_done[i];
            3:       return int'(errt[i]);
            4:       return int'(ovr[i]);
            default: return 0;
        endcase
    endfunction

    // what: 0 state, 1 avg_valid, 2 samples done (>=), 3 err_timeout, 4 overrun
    task automatic wait_for(input int i, input int what, input int val, input int budget,
                            input string tag);
        bit hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clock);
            hit = (what == 2) ? (sig(i, what) >= val) : (sig(i, what) == val);
        end
        check({tag, "_reached"}, 32'(hit), 32'd1);
    endtask

    task automatic pulse_ready(input int i);
        ready[i] = 1'b1;
        @(negedge clock);
        ready[i] = 1'b0;
    endtask

    task automatic pulse_clear(input int i);
        clr[i] = 1'b1;
        @(negedge clock);
        clr[i] = 1'b0;
    endtask

    task automatic do_reset(input int i);
        rstn[i] = 1'b0;
        en[i] = 1'b0;
        clr[i] = 1'b0;
        ready[i] = 1'b0;
        adc_mode[i] = 0;
        repeat (3) @(negedge clock);
        samples_done[i] = 0;
        if (i == 0) begin
            adc_q0.delete();
            start_q0.delete();
            busy_cnt = 0;
            done_cnt = 0;
        end else begin
            adc_q1.delete();
            start_q1.delete();
        end
        rstn[i] = 1'b1;
        @(negedge clock);
    endtask

    function automatic int gap0(input int k);
        return (start_q0.size() > k + 1) ? start_q0[k+1] - start_q0[k] : -1;
    endfunction

    function automatic int gap1(input int k);
        return (start_q1.size() > k + 1) ? start_q1[k+1] - start_q1[k] : -1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rstn[i] = 1'b0; en[i] = 1'b0; clr[i] = 1'b0; ready[i] = 1'b0;
        end
        repeat (3) @(negedge clock);
        check("rst_nstart", nstart[0], 1);
        check("rst_avg_out", avgo[0], 0);
        check("rst_avg_valid", avgv[0], 0);
        check("rst_err", errt[0], 0);
        check("rst_overrun", ovr[0], 0);
        check("rst_state", st[0], 0);
        check("rst_nstart2", nstart[1], 1);

        // Three batches: 10..13 -> 12, all 31 -> 31, 0,0,0,1 -> 0
        do_reset(0);
        adc_q0 = '{10, 11, 12, 13, 31, 31, 31, 31, 0, 0, 0, 1};
        exp_q = '{5'd12, 5'd31, 5'd0};
        en[0] = 1'b1;
        wait_for(0, 1, 1, 400, "b1_valid");
        check("b1_avg", avgo[0], exp_q.pop_front());
        check("b1_overrun", ovr[0], 0);
        check("b1_gap0", gap0(0), 64);
        check("b1_gap1", gap0(1), 64);
        check("b1_gap2", gap0(2), 64);
        pulse_ready(0);
        check("b1_accepted", avgv[0], 0);
        wait_for(0, 1, 1, 400, "b2_valid");
        check("b2_avg_max", avgo[0], exp_q.pop_front());
        pulse_ready(0);
        wait_for(0, 1, 1, 400, "b3_valid");
        check("b3_avg", avgo[0], exp_q.pop_front());
        en[0] = 1'b0;
        repeat (5) @(negedge clock);
        check("b3_idle", st[0], 0);
        check("b3_starts", start_q0.size(), 12);

        // Overrun: 1..4 -> 3 left unconsumed, 5..8 -> 7 replaces it
        do_reset(0);
        adc_q0 = '{1, 2, 3, 4, 5, 6, 7, 8};
        en[0] = 1'b1;
        wait_for(0, 1, 1, 400, "ov_first_valid");
        check("ov_first_avg", avgo[0], 3);
        check("ov_first_flag", ovr[0], 0);
        wait_for(0, 4, 1, 400, "ov_flag");
        en[0] = 1'b0;
        check("ov_second_avg", avgo[0], 7);
        check("ov_valid_held", avgv[0], 1);
        pulse_clear(0);
        check("ov_cleared", ovr[0], 0);
        check("ov_valid_after_clear", avgv[0], 1);
        pulse_ready(0);
        check("ov_valid_fall", avgv[0], 0);

        // Ready on the same clock as the next result: no overrun
        do_reset(0);
        adc_q0 = '{4, 4, 4, 4, 9, 9, 9, 9};
        en[0] = 1'b1;
        wait_for(0, 1, 1, 400, "sc_first_valid");
        check("sc_first_avg", avgo[0], 4);
        wait_for(0, 2, 7, 400, "sc_seven");
        wait_for(0, 0, 2, 100, "sc_busy8");
        wait_for(0, 0, 4, 100, "sc_gap8");
        ready[0] = 1'b1;
        @(negedge clock);
        ready[0] = 1'b0;
        check("sc_avg", avgo[0], 9);
        check("sc_valid", avgv[0], 1);
        check("sc_no_overrun", ovr[0], 0);
        en[0] = 1'b0;

        // Timeout in WAIT_BUSY, then in WAIT_DONE
        do_reset(0);
        adc_mode[0] = 1;
        en[0] = 1'b1;
        wait_for(0, 3, 1, 200, "to_busy_err");
        en[0] = 1'b0;
        check("to_busy_state", st[0], 0);
        check("to_busy_nstart", nstart[0], 1);
        check("to_busy_len", busy_cnt, 63);
        pulse_clear(0);
        check("to_err_cleared", errt[0], 0);
        adc_mode[0] = 2;
        done_cnt = 0;
        en[0] = 1'b1;
        wait_for(0, 3, 1, 200, "to_done_err");
        en[0] = 1'b0;
        check("to_done_state", st[0], 0);
        check("to_done_nstart", nstart[0], 1);
        check("to_done_len", done_cnt, 63);
        check("to_done_no_valid", avgv[0], 0);
        adc_mode[0] = 0;
        repeat (5) @(negedge clock);

        // Enable dropped during the 3rd conversion; restart averages only new samples
        do_reset(0);
        adc_q0 = '{20, 21, 22, 1, 2, 3, 5};
        en[0] = 1'b1;
        wait_for(0, 2, 2, 300, "dis_two");
        wait_for(0, 0, 2, 100, "dis_busy3");
        wait_for(0, 0, 3, 100, "dis_done3");
        en[0] = 1'b0;
        wait_for(0, 2, 3, 50, "dis_third_done");
        wait_for(0, 0, 0, 20, "dis_idle");
        check("dis_no_valid", avgv[0], 0);
        check("dis_starts", start_q0.size(), 3);
        en[0] = 1'b1;
        wait_for(0, 1, 1, 400, "dis_new_valid");
        check("dis_new_avg", avgo[0], 3);
        en[0] = 1'b0;

        // Asynchronous reset while in WAIT_DONE with a result pending
        do_reset(0);
        adc_q0 = '{7, 7, 7, 7, 7};
        en[0] = 1'b1;
        wait_for(0, 1, 1, 400, "ar_valid");
        check("ar_avg", avgo[0], 7);
        wait_for(0, 0, 2, 100, "ar_busy");
        wait_for(0, 0, 3, 100, "ar_done");
        rstn[0] = 1'b0;
        #1;
        check("ar_avg_out", avgo[0], 0);
        check("ar_avg_valid", avgv[0], 0);
        check("ar_state", st[0], 0);
        check("ar_nstart", nstart[0], 1);
        do_reset(0);

        // PERIOD=2 with a 20-clock ADC: starts back to back, 3,3,4,4 -> 4
        do_reset(1);
        adc_q1 = '{3, 3, 4, 4};
        en[1] = 1'b1;
        wait_for(1, 1, 1, 300, "p2_valid");
        check("p2_avg", avgo[1], 4);
        check("p2_gap0", gap1(0), 22);
        check("p2_gap1", gap1(1), 22);
        check("p2_gap2", gap1(2), 22);
        wait_for(1, 0, 2, 50, "p2_busy");
        rstn[1] = 1'b0;
        #1;
        check("p2_rst_nstart", nstart[1], 1);
        check("p2_rst_state", st[1], 0);
        en[1] = 1'b0;
        @(negedge clock);
        rstn[1] = 1'b1;
        repeat (3) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
